row_skew_feeder: RTL and testbench
==================================

# row_skew_feeder

Row-side input stage of the systolic array. It buffers up to DEPTH operands for each of the three array rows, then on `start` replays them as three aligned-rate streams. Row r is delayed r-1 cycles to give the diagonal wavefront the array expects. Its outputs drive the array's `data_row_in1..3` / `valid_row_in1..3` inputs directly.

## Interface
- `DATA_WIDTH`, 8, operand width (matches array `Data_width`)
- `DEPTH`, 16, entries per row buffer; power of two, ≥2
- `AW`, `$clog2(DEPTH)`, derived; not overridden
- `clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  load strobe; honoured only in IDLE
- `wr_row`  in  2  target row 1..3; value 0 is ignored
- `wr_data`  in  DATA_WIDTH  operand to append to the selected row
- `start`  in  1  single-cycle replay request
- `len`  in  AW+1  replay length, 1..DEPTH; sampled with `start`
- `wr_full`  out  3  bit r-1 high when row r holds DEPTH entries
- `busy`  out  1  replay in progress
- `done`  out  1  one-cycle pulse at end of replay
- `data_row1..3`  out  DATA_WIDTH  row operand streams
- `valid_row1..3`  out  1  qualifiers for `data_row1..3`

## Operation
- Three row buffers, each with its own write counter `wcnt_r` (0..DEPTH). `wr_en` in IDLE with `wr_row`=r and `wcnt_r`<DEPTH stores at `wcnt_r`, then increments.
- Writes to a full row, writes with `wr_row`=0, and writes while `busy` are dropped silently.
- FSM has four states.
  - IDLE: `start` with 1≤`len`≤DEPTH latches `len`, clears the read index `k`, and goes to RUN. `start` with `len`=0 or `len`>DEPTH is ignored.
  - RUN: each cycle issues index `k` to all rows and increments `k`. After issuing `k`=`len`-1 it goes to DRAIN.
  - DRAIN: counts 2 cycles so the skew pipe can empty, then goes to DONE.
  - DONE: pulses `done`, clears all `wcnt_r` (buffers consumed), and returns to IDLE.
- Output data for index `k` on row r is `buf_r[k]` if `k` < `wcnt_r` at start, otherwise 0. `valid_row_r` is still high for these padded entries.
- Row skew: row 1 has 0 extra cycles, row 2 has 1 register stage, row 3 has 2 register stages. `data` and `valid` move through the stages together.
- `start` during `busy` is ignored. `wr_full` reflects `wcnt_r`==DEPTH.
- Reset, including mid-replay: FSM to IDLE; `k`, `wcnt_r`, and all skew registers to 0; replay is abandoned. Buffer contents are don't-care.

## Timing
- Reset values: `busy`, `done`, `wr_full`, all `valid_row*` and all `data_row*` are 0.
- `start` is sampled high at edge T.
  - `busy` is high from cycle T+1 through the `done` cycle inclusive.
  - Row 1 is valid in cycles T+1..T+len, row 2 in T+2..T+len+1, row 3 in T+3..T+len+2.
  - `done` is high in cycle T+len+3. The next `start` is accepted from cycle T+len+4.
- Between replays, `valid_row*` is 0 and `data_row*` is 0.
- Write-to-read: a write accepted at edge W is visible to a `start` sampled at edge W+1.

## Configuration
- `ROW_FEEDER_SKEW_EN` defined: skew stages as above, DRAIN lasts 2 cycles, `done` at T+len+3.
- `ROW_FEEDER_SKEW_EN` undefined:
  - No skew registers; all three rows are valid in cycles T+1..T+len.
  - DRAIN is skipped and `done` is at T+len+1.
  - Port list is unchanged.

## Structure
- Shared package `sa_pkg`: `DATA_WIDTH` default, the FSM state enum (IDLE/RUN/DRAIN/DONE), and the row count constant 3.
- One sub-module, `skew_delay`: a parameterised N-stage data+valid shift register with async active-low clear. It is instantiated with N=1 for row 2 and N=2 for row 3, and omitted when `ROW_FEEDER_SKEW_EN` is undefined.

## Test plan
- Reset check: assert `rst`=0 mid-replay, release → all outputs 0, FSM IDLE, `wr_full`=000.
- Full load and replay, skew on: load rows 1/2/3 with 0x10+i, 0x20+i, 0x30+i (i=0..3), `start` with `len`=4 at T.
  - Row 1 gives 10,11,12,13 in T+1..T+4.
  - Row 3 gives 30..33 in T+3..T+6.
  - `done` in T+7.
- Padding: row 2 gets only 2 writes (AA, BB), `len`=4 → row 2 outputs AA, BB, 00, 00, each with valid high.
- Capacity: 17 writes to row 1 with DEPTH=16 → `wr_full`[0] high after the 16th; the 17th is dropped; replay with `len`=16 ends with entry 15.
- Illegal or overlapping commands:
  - `start` with `len`=0 → no `busy`.
  - `start` and `wr_en` during `busy` → ignored; the first replay completes unchanged.
- Skew disabled (`ROW_FEEDER_SKEW_EN` undefined), `len`=3 → all rows valid T+1..T+3, `done` at T+4.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array front end: default operand width,
// row count and the row feeder's replay FSM states.
package sa_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int NUM_ROWS           = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/skew_delay.sv
// N-stage shift register that delays a data word and its valid qualifier
// together, with asynchronous active-low clear.
module skew_delay #(
  parameter int N = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q [N];
  logic [N-1:0] valid_q;

  // NOTE: sequential state is assigned with <= so every stage samples the
  // value its predecessor held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) data_q[i] <= '0;
      valid_q <= '0;
    end else begin
      data_q[0]  <= data_i;
      valid_q[0] <= valid_i;
      for (int i = 1; i < N; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign data_o  = data_q[N-1];
  assign valid_o = valid_q[N-1];

endmodule

// File: rtl/row_skew_feeder.sv
// Row-side input stage: buffers operands per row and replays them on start.
// Define ROW_FEEDER_SKEW_EN to delay row 2 by one and row 3 by two cycles.
module row_skew_feeder
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [1:0]            wr_row,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [AW:0]           len,
  output logic [NUM_ROWS-1:0]   wr_full,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_row1,
  output logic [DATA_WIDTH-1:0] data_row2,
  output logic [DATA_WIDTH-1:0] data_row3,
  output logic                  valid_row1,
  output logic                  valid_row2,
  output logic                  valid_row3
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [NUM_ROWS][DEPTH];
  logic [AW:0]           wcnt_q [NUM_ROWS];
  logic [NUM_ROWS-1:0]   wr_sel;

  state_t      state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW:0] len_q, len_d;
  logic        drain_q, drain_d;
  logic        clr_wcnt;

  logic [DATA_WIDTH-1:0] rd_data [NUM_ROWS];
  logic                  row_valid;

  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      wr_full[r] = (wcnt_q[r] == DEPTH_C);
      wr_sel[r]  = wr_en && (state_q == IDLE) && (wr_row == 2'(r + 1)) && !wr_full[r];
    end
  end

  // NOTE: the buffer array has no reset so it maps onto plain RAM; its
  // contents are meaningless until the write counters say otherwise.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_ROWS; r++)
      if (wr_sel[r]) mem_q[r][wcnt_q[r][AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_ROWS; r++) wcnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (clr_wcnt)       wcnt_q[r] <= '0;
        else if (wr_sel[r]) wcnt_q[r] <= wcnt_q[r] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      len_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
      drain_q <= drain_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    len_d    = len_q;
    drain_d  = drain_q;
    clr_wcnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len != '0) && (len <= DEPTH_C)) begin
          len_d   = len;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        k_d = k_q + 1'b1;
        if ({1'b0, k_q} == len_q - 1'b1) begin
`ifdef ROW_FEEDER_SKEW_EN
          drain_d = 1'b0;
          state_d = DRAIN;
`else
          state_d = DONE;
`endif
        end
      end
      DRAIN: begin
        // Two cycles let the deepest skew stage empty before done.
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE: begin
        clr_wcnt = 1'b1;
        drain_d  = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Indices past a row's fill level read as zero but stay valid.
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      rd_data[r] = '0;
      if ((state_q == RUN) && ({1'b0, k_q} < wcnt_q[r])) rd_data[r] = mem_q[r][k_q];
    end
  end

  assign row_valid  = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign data_row1  = rd_data[0];
  assign valid_row1 = row_valid;

`ifdef ROW_FEEDER_SKEW_EN
  skew_delay #(.N(1), .W(DATA_WIDTH)) u_skew_row2 (
    .clk     (clk),
    .rst_n   (rst),
    .data_i  (rd_data[1]),
    .valid_i (row_valid),
    .data_o  (data_row2),
    .valid_o (valid_row2)
  );

  skew_delay #(.N(2), .W(DATA_WIDTH)) u_skew_row3 (
    .clk     (clk),
    .rst_n   (rst),
    .data_i  (rd_data[2]),
    .valid_i (row_valid),
    .data_o  (data_row3),
    .valid_o (valid_row3)
  );
`else
  assign data_row2  = rd_data[1];
  assign valid_row2 = row_valid;
  assign data_row3  = rd_data[2];
  assign valid_row3 = row_valid;
`endif

endmodule

// File: tb/tb_row_skew_feeder.sv
// Self-checking bench for row_skew_feeder: table-driven loads, hand-written
// corner sequences and randomized replays against a queue-based row model.
module tb_row_skew_feeder;

`ifdef ROW_FEEDER_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [7:0] wr_data;
  logic       start;
  logic [4:0] len;
  logic [2:0] wr_full;
  logic       busy, done;
  logic [7:0] data_row1, data_row2, data_row3;
  logic       valid_row1, valid_row2, valid_row3;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq [3][$];

  typedef struct {
    logic [1:0] row;
    logic [7:0] data;
    logic [2:0] exp_full;
  } wr_vec_t;

  row_skew_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .start      (start),
    .len        (len),
    .wr_full    (wr_full),
    .busy       (busy),
    .done       (done),
    .data_row1  (data_row1),
    .data_row2  (data_row2),
    .data_row3  (data_row3),
    .valid_row1 (valid_row1),
    .valid_row2 (valid_row2),
    .valid_row3 (valid_row3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {35'b0, busy, done, valid_row3, valid_row2, valid_row1,
            data_row3, data_row2, data_row1};
  endfunction

  // Expected outputs in cycle c after the start edge, from the replay rules.
  function automatic logic [63:0] expect_at(int c, int l);
    logic [7:0] d [3];
    logic [2:0] v;
    int         done_c;
    done_c = l + 1 + 2 * SKEW;
    for (int r = 0; r < 3; r++) begin
      int idx;
      idx  = c - 1 - SKEW * r;
      v[r] = (idx >= 0) && (idx < l);
      d[r] = (v[r] && idx < mq[r].size()) ? mq[r][idx] : 8'h00;
    end
    return {35'b0, (c <= done_c), (c == done_c), v, d[2], d[1], d[0]};
  endfunction

  function automatic logic [2:0] model_full();
    logic [2:0] f;
    for (int r = 0; r < 3; r++) f[r] = (mq[r].size() == DEPTH);
    return f;
  endfunction

  // Called at a falling edge; returns at the falling edge after the write edge.
  task automatic do_write(input logic [1:0] row, input logic [7:0] data);
    wr_en = 1'b1; wr_row = row; wr_data = data;
    if (row != 2'd0 && mq[row-1].size() < DEPTH) mq[row-1].push_back(data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic replay(input int l, input bit noise);
    int done_c;
    done_c = l + 1 + 2 * SKEW;
    start = 1'b1; len = 5'(l);
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      check($sformatf("replay_l%0d_c%0d", l, c), out_vec(), expect_at(c, l));
      if (noise && c < done_c) begin
        wr_en   = 1'($urandom);
        wr_row  = 2'($urandom_range(0, 3));
        wr_data = 8'($urandom);
        start   = 1'($urandom);
        len     = 5'($urandom_range(1, DEPTH));
      end
    end
    for (int r = 0; r < 3; r++) mq[r].delete();
    @(negedge clk);
    check($sformatf("idle_after_l%0d", l), {out_vec(), 29'b0, wr_full}, 64'd0);
  endtask

  wr_vec_t tbl_full [12];
  wr_vec_t tbl_pad  [5];

  initial begin
    for (int i = 0; i < 4; i++) begin
      tbl_full[i]     = '{2'd1, 8'(8'h10 + i), 3'b000};
      tbl_full[4 + i] = '{2'd2, 8'(8'h20 + i), 3'b000};
      tbl_full[8 + i] = '{2'd3, 8'(8'h30 + i), 3'b000};
    end
    tbl_pad[0] = '{2'd2, 8'hAA, 3'b000};
    tbl_pad[1] = '{2'd2, 8'hBB, 3'b000};
    tbl_pad[2] = '{2'd0, 8'hEE, 3'b000};
    tbl_pad[3] = '{2'd1, 8'h55, 3'b000};
    tbl_pad[4] = '{2'd3, 8'h66, 3'b000};

    rst = 1'b0; wr_en = 1'b0; wr_row = 2'd0; wr_data = 8'h00; start = 1'b0; len = 5'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {out_vec(), 29'b0, wr_full}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl_full[i]) begin
      do_write(tbl_full[i].row, tbl_full[i].data);
      check($sformatf("tbl_full_wr%0d", i), {61'b0, wr_full}, {61'b0, tbl_full[i].exp_full});
    end
    replay(4, 1'b0);

    foreach (tbl_pad[i]) begin
      do_write(tbl_pad[i].row, tbl_pad[i].data);
      check($sformatf("tbl_pad_wr%0d", i), {61'b0, wr_full}, {61'b0, tbl_pad[i].exp_full});
    end
    replay(4, 1'b0);

    // Capacity: the 17th write to row 1 must be dropped.
    for (int i = 0; i < DEPTH + 1; i++) begin
      do_write(2'd1, 8'(8'h40 + i));
      check($sformatf("cap_full_%0d", i), {61'b0, wr_full}, (i >= DEPTH - 1) ? 64'd1 : 64'd0);
    end
    replay(DEPTH, 1'b0);

    // Illegal lengths leave the feeder idle and the buffers intact.
    do_write(2'd3, 8'h9C);
    start = 1'b1; len = 5'd0;
    @(negedge clk);
    start = 1'b0;
    check("start_len0", {63'b0, busy}, 64'd0);
    start = 1'b1; len = 5'd17;
    @(negedge clk);
    start = 1'b0;
    check("start_len17", {63'b0, busy}, 64'd0);
    replay(2, 1'b0);

    // Start and writes during busy are ignored.
    for (int i = 0; i < 5; i++) do_write(2'(1 + i % 3), 8'(8'hC0 + i));
    replay(5, 1'b1);

    // Reset mid-replay abandons it and clears the write counters.
    for (int i = 0; i < 3; i++) do_write(2'd2, 8'(8'h70 + i));
    start = 1'b1; len = 5'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_mid_replay", {out_vec(), 29'b0, wr_full}, 64'd0);
    for (int r = 0; r < 3; r++) mq[r].delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after_reset_idle", {out_vec(), 29'b0, wr_full}, 64'd0);
    do_write(2'd1, 8'h77);
    replay(2, 1'b0);

    for (int round = 0; round < 8; round++) begin
      int n;
      n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++) begin
        do_write(2'($urandom_range(0, 3)), 8'($urandom));
        check($sformatf("rnd%0d_full_%0d", round, i), {61'b0, wr_full}, {61'b0, model_full()});
      end
      replay($urandom_range(1, DEPTH), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
